ascii_hex_to_byte: RTL
======================

// Module: ascii_hex_to_byte
// PURPOSE
//   Decodes a stream of ASCII hex characters from uart_rx (rx_valid/rx_data)
//   into binary bytes: two hex digits form one byte, high nibble first.
//   Sits between uart_rx and any consumer that takes typed hex from a terminal
//   (e.g. picocom at 9600 baud, 12 MHz CLK). It is the input-side counterpart
//   of the byte-to-hex-echo path. Output is a valid/ready holding register.
// PARAMETERS
//   ALLOW_LOWER   1            1: 'a'-'f' accepted as 10-15; 0: treated as invalid
//   SINGLE_DIGIT  0            1: separator after one digit emits 0x0N; 0: error
//   TIMEOUT_CYCLES 12_000_000  cycles in WAIT_LO before pending nibble dropped; 0 = off
// PORTS
//   CLK           in   1  system clock
//   resetn        in   1  asynchronous active-low reset
//   rx_valid      in   1  one-cycle strobe, rx_data holds a received char
//   rx_data       in   8  received ASCII char
//   out_valid     out  1  decoded byte available in out_data
//   out_data      out  8  decoded byte
//   out_ready     in   1  consumer accepts out_data when out_valid&&out_ready
//   err_char      out  1  one-cycle pulse: invalid char (or lone digit, SINGLE_DIGIT=0)
//   err_overflow  out  1  one-cycle pulse: completed byte dropped, holding reg full
//   nibble_pending out 1  high while in WAIT_LO
// BEHAVIOUR
// - Reset (async, resetn=0): state WAIT_HI, hi nibble 0, timeout counter 0,
//   out_valid=0, out_data=0x00, err_char=0, err_overflow=0, nibble_pending=0.
//   Reset mid-byte discards pending nibble and held output.
// - Char classes: digit '0'-'9'(0x30-0x39)->0-9, 'A'-'F'->10-15,
//   'a'-'f'->10-15 iff ALLOW_LOWER; separator = 0x20,0x09,0x0D,0x0A,','; else invalid.
// - Only cycles with rx_valid=1 are classified; back-to-back strobes supported.
// - FSM WAIT_HI: digit -> latch hi nibble, go WAIT_LO; separator -> stay;
//   invalid -> err_char pulse, stay.
// - FSM WAIT_LO: digit -> byte={hi,digit} completed, go WAIT_HI;
//   separator -> SINGLE_DIGIT ? byte={4'h0,hi} completed : err_char; go WAIT_HI;
//   invalid -> err_char pulse, drop hi, go WAIT_HI.
// - Timeout: counter clears on entry to WAIT_LO and on any rx_valid; increments
//   each WAIT_LO cycle; at TIMEOUT_CYCLES-1 with no rx_valid -> drop hi, WAIT_HI,
//   no error pulse. rx_valid on the expiry cycle wins (char processed normally).
//   Counter width $clog2(TIMEOUT_CYCLES+1), min 1.
// - Latency: out_valid/out_data update on the clock edge after the completing
//   rx_valid cycle (1 cycle). err_* pulses are registered, same latency, 1 cycle wide.
// - Handshake: out_valid held, out_data stable until out_valid&&out_ready at an edge.
//   Completion with out_valid=0 or out_ready=1 same cycle -> load new byte, out_valid=1
//   (no gap). Completion with out_valid=1, out_ready=0 -> new byte dropped,
//   old byte kept, err_overflow pulse.
// - out_ready ignored while out_valid=0. nibble_pending is a direct state decode.
// TESTING
// 1. "4","1" strobes, out_ready=0 -> out_valid=1,out_data=0x41 one cycle after
//    '1', held 20 cycles; out_ready=1 -> out_valid=0 next edge.
// 2. ALLOW_LOWER=1 "a","F" -> 0xAF; ALLOW_LOWER=0 same -> err_char on 'a', then
//    'F' is hi nibble, nibble_pending=1, no out_valid.
// 3. "3","G" -> err_char pulse, no byte; then " ","7","E" -> 0x7E, no error.
// 4. out_ready=0: "1","2","3","4" -> out_data=0x12, err_overflow pulse after '4';
//    out_ready=1 same cycle as completion instead -> 0x34 loaded, no err_overflow.
// 5. TIMEOUT_CYCLES=100: "5", idle 100 cycles -> nibble_pending=0; "6","7" -> 0x67.
//    SINGLE_DIGIT=1: "9",CR -> 0x09.
// 6. "9", resetn low 3 cycles mid-byte, release; "0","1" -> 0x01; all outputs 0
//    during reset.

Source files
------------

// File: rtl/ascii_hex_to_byte.sv
// ascii_hex_to_byte: turns a stream of ASCII hex characters from uart_rx into
// bytes (two digits per byte, high nibble first). The decoded byte is offered
// through a valid/ready holding register; bad characters, lone digits,
// overflows and timeouts are handled in the character FSM below.
module ascii_hex_to_byte #(
  parameter bit          ALLOW_LOWER    = 1'b1,
  parameter bit          SINGLE_DIGIT   = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 12_000_000
) (
  input  logic       CLK,
  input  logic       resetn,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       err_char,
  output logic       err_overflow,
  output logic       nibble_pending
);

  localparam logic [0:0] WAIT_HI = 1'b0;
  localparam logic [0:0] WAIT_LO = 1'b1;

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  logic [0:0]       state, state_nx;
  logic [3:0]       hi, hi_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  logic             is_digit, is_sep;
  logic [3:0]       digit;
  logic             complete, char_bad;
  logic [7:0]       byte_nx;

  // Classify the incoming character: hex digit value or separator.
  always_comb begin
    is_digit = 1'b0;
    is_sep   = 1'b0;
    digit    = '0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      is_digit = 1'b1;
      digit    = rx_data[3:0];
    end else if (rx_data >= 8'h41 && rx_data <= 8'h46) begin
      is_digit = 1'b1;
      digit    = rx_data[3:0] + 4'd9;
    end else if (ALLOW_LOWER && rx_data >= 8'h61 && rx_data <= 8'h66) begin
      is_digit = 1'b1;
      digit    = rx_data[3:0] + 4'd9;
    end
    case (rx_data)
      8'h20, 8'h09, 8'h0D, 8'h0A, 8'h2C: is_sep = 1'b1;
      default:                           is_sep = 1'b0;
    endcase
  end

  // Character FSM and WAIT_LO timeout; a strobe on the expiry cycle takes priority.
  always_comb begin
    state_nx = state;
    hi_nx    = hi;
    cnt_nx   = '0;
    complete = 1'b0;
    char_bad = 1'b0;
    byte_nx  = 8'h00;
    if (rx_valid) begin
      if (state == WAIT_HI) begin
        if (is_digit) begin
          hi_nx    = digit;
          state_nx = WAIT_LO;
        end else if (!is_sep) begin
          char_bad = 1'b1;
        end
      end else begin
        state_nx = WAIT_HI;
        hi_nx    = '0;
        if (is_digit) begin
          complete = 1'b1;
          byte_nx  = {hi, digit};
        end else if (is_sep && SINGLE_DIGIT) begin
          complete = 1'b1;
          byte_nx  = {4'h0, hi};
        end else begin
          char_bad = 1'b1;
        end
      end
    end else if (state == WAIT_LO && TIMEOUT_CYCLES > 0) begin
      if (cnt == CNT_LAST) begin
        state_nx = WAIT_HI;
        hi_nx    = '0;
      end else begin
        cnt_nx = cnt + 1'b1;
      end
    end
  end

  // FSM state, pending high nibble and timeout counter.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state <= WAIT_HI;
      hi    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      hi    <= hi_nx;
      cnt   <= cnt_nx;
    end
  end

  // Output holding register and registered error pulses.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      err_char     <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      err_char     <= char_bad;
      err_overflow <= complete && out_valid && !out_ready;
      if (complete && (!out_valid || out_ready)) begin
        out_valid <= 1'b1;
        out_data  <= byte_nx;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign nibble_pending = (state == WAIT_LO);

endmodule
